// File: rtl/riscv_pkg.sv
// Shared RV32I load/store constants and the responder FSM encoding.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Stores only come in signed-size flavours; loads accept all five encodings.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    if (we) return !(f3 inside {F3_B, F3_H, F3_W});
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane steering for byte/half/word accesses: write byte enables, replicated
// write data, extended load data and the natural-alignment check.
module load_store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
  assign half_sel = rword[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    be       = 4'b0000;
    wword    = 32'h0;
    rdata    = 32'h0;
    misalign = 1'b0;
    unique case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = {{24{byte_sel[7] && (funct3 == F3_B)}}, byte_sel};
      end
      F3_H, F3_HU: begin
        misalign = addr_lo[0];
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        wword    = {2{wdata[15:0]}};
        rdata    = {{16{half_sel[15] && (funct3 == F3_H)}}, half_sel};
      end
      F3_W: begin
        misalign = (addr_lo != 2'b00);
        be       = 4'b1111;
        wword    = wdata;
        rdata    = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, served from an internal
// word RAM after LATENCY wait cycles, with error flagging instead of access.
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_f3;
  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, do_access, acc_err, out_of_range, borrow, misalign;
  logic [31:0]      diff, word_off, rword, wword, ext_rdata;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;
  assign do_access = (state == S_ACCESS) && (cnt == 4'd0);

  // A borrow out of the rebase means the address lies below the window.
  assign {borrow, diff} = {1'b0, lat_addr} - {1'b0, BASE_ADDR};
  assign word_off       = diff >> 2;
  assign out_of_range   = borrow || (word_off >= 32'(DEPTH_WORDS));
  assign idx            = word_off[IDX_W-1:0];
  assign rword          = mem[idx];
  assign acc_err        = f3_illegal(lat_f3, lat_we) || misalign || out_of_range;

  load_store_align u_align (
    .funct3   (lat_f3),
    .addr_lo  (lat_addr[1:0]),
    .wdata    (lat_wdata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rdata    (ext_rdata),
    .misalign (misalign)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (accept)         state_next = S_ACCESS;
      S_ACCESS: if (cnt == 4'd0)    state_next = S_RESP;
      S_RESP:   if (rsp_ready)      state_next = S_IDLE;
      default:                      state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_f3    <= req_funct3;
        cnt       <= 4'(LATENCY);
      end else if ((state == S_ACCESS) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || lat_we) ? 32'h0 : ext_rdata;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset, only the commit is suppressed.
  always_ff @(posedge clk) begin
    if (!reset && do_access && lat_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized phase against a byte-array reference model.
module tb_data_mem_responder;

  localparam int          DEPTH   = 256;
  localparam int          LAT     = 1;
  localparam int          BUDGET  = 50;
  localparam int          NBYTES  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mbytes [NBYTES];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .BASE_ADDR   (32'h0)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  // Reference: byte-addressed memory, size/sign from funct3, errors from the access rules.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int n;
    bit sgn;
    logic [31:0] val;
    n = 0;
    sgn = 0;
    case (f3)
      3'b000: begin n = 1; sgn = 1; end
      3'b001: begin n = 2; sgn = 1; end
      3'b010: begin n = 4; sgn = 0; end
      3'b100: begin n = (we ? 0 : 1); end
      3'b101: begin n = (we ? 0 : 2); end
      default: n = 0;
    endcase
    rd = 32'h0;
    er = 1'b0;
    if (n == 0)                          er = 1'b1;
    else if ((addr % n) != 0)            er = 1'b1;
    else if (addr >= 32'(NBYTES))        er = 1'b1;
    if (er) return;
    if (we) begin
      for (int k = 0; k < n; k++) mbytes[addr + k] = wdata[8*k +: 8];
    end else begin
      val = 32'h0;
      for (int k = 0; k < n; k++) val[8*k +: 8] = mbytes[addr + k];
      if (sgn && n < 4 && val[8*n-1]) val = val | ~((32'h1 << (8*n)) - 32'h1);
      rd = val;
    end
  endtask

  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    n = 0;
    while (!req_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      errors++;
      $display("FAIL req_ready_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!rsp_valid && lat < BUDGET);
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_valid_timeout actual=0 expected=1");
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({tag, ".idle_after"}, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_er,
                         input string tag);
    logic [31:0] rd;
    logic        er;
    int          lat;
    send_req(we, addr, wdata, f3);
    wait_rsp(rd, er, lat);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, {31'h0, er}, {31'h0, exp_er});
    check({tag, ".latency"}, 32'(lat), 32'(1 + LAT));
    finish_rsp(tag);
  endtask

  // Runs a transaction expecting whatever the reference model predicts, updating the model.
  task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input string tag);
    logic [31:0] rd;
    logic        er;
    model_access(we, addr, wdata, f3, rd, er);
    run_txn(we, addr, wdata, f3, rd, er, tag);
  endtask

  initial begin
    logic [31:0] rd, addr, wdata;
    logic        er, we;
    logic [2:0]  f3;
    int          lat;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_funct3 = 3'b000; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset.rsp_rdata", rsp_rdata, 32'h0);
    check("reset.rsp_err", {31'h0, rsp_err}, 32'h0);
    check("reset.req_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < DEPTH; i++) model_txn(1'b1, 32'(i * 4), init_word(i), 3'b010, "init_sw");

    vecs.push_back('{1'b1, 32'h010, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0});
    vecs.push_back('{1'b0, 32'h013, 32'h0,        3'b100, 32'h000000DE, 1'b0});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h012, 32'h0,        3'b101, 32'h0000DEAD, 1'b0});
    vecs.push_back('{1'b1, 32'h011, 32'hAAAAAA55, 3'b000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0});
    vecs.push_back('{1'b1, 32'h012, 32'hFFFF1234, 3'b001, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        3'b010, 32'h123455EF, 1'b0});
    vecs.push_back('{1'b0, 32'h012, 32'h0,        3'b010, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h011, 32'h0000FFFF, 3'b001, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h400, 32'h0,        3'b010, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        3'b011, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h010, 32'h00000077, 3'b100, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h400, 32'h00000077, 3'b010, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        3'b010, 32'h123455EF, 1'b0});
    vecs.push_back('{1'b0, 32'h3FC, 32'h0,        3'b010, init_word(255), 1'b0});
    vecs.push_back('{1'b0, 32'h3FF, 32'h0,        3'b100, {24'h0, init_word(255)[31:24]}, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
              vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er);
    end

    // Response held for 5 cycles while a stray store is offered; it must be ignored.
    send_req(1'b0, 32'h010, 32'h0, 3'b010);
    wait_rsp(rd, er, lat);
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h010;
      req_wdata = 32'hFFFFFFFF; req_funct3 = 3'b010;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d.rsp_valid", c), {31'h0, rsp_valid}, 32'h1);
      check($sformatf("hold%0d.rsp_rdata", c), rsp_rdata, 32'h123455EF);
      check($sformatf("hold%0d.req_ready", c), {31'h0, req_ready}, 32'h0);
    end
    req_valid = 1'b0;
    finish_rsp("hold");
    check("hold.rsp_valid_after", {31'h0, rsp_valid}, 32'h0);
    run_txn(1'b0, 32'h010, 32'h0, 3'b010, 32'h123455EF, 1'b0, "hold_reread");

    // Reset while counting down in ACCESS drops the store.
    send_req(1'b1, 32'h010, 32'h0, 3'b010);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_mid.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_mid.req_ready", {31'h0, req_ready}, 32'h1);
    run_txn(1'b0, 32'h010, 32'h0, 3'b010, 32'h123455EF, 1'b0, "rst_mid_reread");

    // Reset on the commit edge itself must also suppress the write.
    send_req(1'b1, 32'h010, 32'h0, 3'b010);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_commit.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_commit.req_ready", {31'h0, req_ready}, 32'h1);
    run_txn(1'b0, 32'h010, 32'h0, 3'b010, 32'h123455EF, 1'b0, "rst_commit_reread");

    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'($urandom_range(NBYTES, NBYTES + 64));
        default: addr = 32'($urandom_range(0, NBYTES - 1));
      endcase
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
      wdata = $urandom;
      model_txn(we, addr, wdata, f3, $sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
